// File: rtl/dcache_controller.sv
// Write-back / write-allocate controller for a 2-way data cache: serves CPU word hits from the SRAM
// and walks victim writeback plus line refill over a single-line memory handshake on a miss.
module dcache_controller #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int IDX_W  = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [31:0]         cpu_data_i,
    input  logic                cpu_MemRead_i,
    input  logic                cpu_MemWrite_i,
    output logic [31:0]         cpu_data_o,
    output logic                cpu_stall_o,
    output logic [IDX_W-1:0]    sram_addr_o,
    output logic [ADDR_W-IDX_W-4:0] sram_tag_o,
    output logic [LINE_W-1:0]   sram_data_o,
    output logic                sram_enable_o,
    output logic                sram_write_o,
    input  logic [ADDR_W-IDX_W-4:0] sram_tag_i,
    input  logic [LINE_W-1:0]   sram_data_i,
    input  logic                sram_hit_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i,
    output logic [2:0]          dbg_state_o
);

    localparam int TAG_W = ADDR_W - IDX_W - 5;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MISS       = 3'd1,
        WRITEBACK  = 3'd2,
        READMISS   = 3'd3,
        READMISSOK = 3'd4
    } state_t;

    state_t              state;
    logic                req;
    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    idx;
    logic [2:0]          word;
    logic [TAG_W-1:0]    victim_tag;
    logic                victim_dirty;
    logic [LINE_W-1:0]   victim_line;
    logic [LINE_W-1:0]   refill_line;
    logic [LINE_W-1:0]   merged_line;
    logic                unused_bits;

    assign req         = cpu_MemRead_i | cpu_MemWrite_i;
    assign tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign idx         = cpu_addr_i[5 +: IDX_W];
    assign word        = cpu_addr_i[4:2];
    assign unused_bits = ^cpu_addr_i[1:0];

    assign cpu_stall_o   = req & ~sram_hit_i;
    assign cpu_data_o    = sram_data_i[{word, 5'd0} +: 32];
    assign sram_addr_o   = idx;
    assign sram_enable_o = req;
    assign dbg_state_o   = state;

    // Tag bits depend only on state so the SRAM hit path has no loop back through sram_hit_i.
    assign sram_tag_o = (state == READMISSOK) ? {1'b1, 1'b0, tag} : {1'b1, 1'b1, tag};

    always_comb begin
        merged_line = sram_data_i;
        merged_line[{word, 5'd0} +: 32] = cpu_data_i;
    end

    always_comb begin
        sram_write_o = 1'b0;
        sram_data_o  = merged_line;
        if (state == READMISSOK) begin
            sram_write_o = 1'b1;
            sram_data_o  = refill_line;
        end else if (state == IDLE && cpu_MemWrite_i && sram_hit_i) begin
            sram_write_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            victim_tag   <= '0;
            victim_dirty <= 1'b0;
            victim_line  <= '0;
            refill_line  <= '0;
        end else begin
            mem_enable_o <= 1'b0;
            case (state)
                IDLE: begin
                    // On a miss the SRAM presents the LRU way, which becomes the victim.
                    if (req && !sram_hit_i) begin
                        victim_tag   <= sram_tag_i[TAG_W-1:0];
                        victim_dirty <= sram_tag_i[TAG_W+1] & sram_tag_i[TAG_W];
                        victim_line  <= sram_data_i;
                        state        <= MISS;
                    end
                end
                MISS: begin
                    mem_enable_o <= 1'b1;
                    if (victim_dirty) begin
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= {victim_tag, idx, 5'd0};
                        mem_data_o  <= victim_line;
                        state       <= WRITEBACK;
                    end else begin
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {tag, idx, 5'd0};
                        state       <= READMISS;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= 1'b0;
                        mem_addr_o   <= {tag, idx, 5'd0};
                        state        <= READMISS;
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        refill_line <= mem_data_i;
                        state       <= READMISSOK;
                    end
                end
                READMISSOK: state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: 2-way LRU SRAM and latency-programmable memory responders, a flat
// word-memory reference model, and a completion scoreboard fed at request issue.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_MemRead_i, cpu_MemWrite_i, cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_enable_o, sram_write_o, sram_hit_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_enable_o, mem_write_o, mem_ack_i;
    logic [2:0]   dbg_state_o;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .dbg_state_o(dbg_state_o)
    );

    int checks = 0;
    int failures = 0;
    logic [40:0] exp_q[$];   // {stall_cycles[7:0], is_load, load_word[31:0]}

    logic [22:0]  tag_tab [4] = '{23'h0, 23'h1, 23'h7FFFFF, 23'h12345};
    logic [255:0] phys [64];
    logic [255:0] arch [64];
    logic [24:0]  s_tag  [16][2];
    logic [255:0] s_data [16][2];
    logic         s_lru  [16];
    logic         hit_way;

    int mem_lat = 1;
    logic spur_req, refill_pending;
    logic [255:0] last_refill, last_wb_data;
    logic [31:0] last_wb_addr, last_rd_addr, last_load;
    int rd_cnt = 0, wb_cnt = 0, ack_cnt = 0, sram_wr_cnt = 0;
    int stall_cnt = 0, last_stall = 0;

    task automatic report();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int find_line(input logic [31:0] a);
        for (int t = 0; t < 4; t++)
            if (tag_tab[t] == a[31:9]) return t * 16 + int'(a[8:5]);
        return -1;
    endfunction

    function automatic int find_way(input logic [31:0] a);
        for (int k = 0; k < 2; k++)
            if (s_tag[a[8:5]][k][24] && s_tag[a[8:5]][k][22:0] == a[31:9]) return k;
        return -1;
    endfunction

    // Stall cycles from the documented latency rules, given current cache residency.
    function automatic int pred_stall(input logic [31:0] a, input int lat);
        logic v;
        if (find_way(a) >= 0) return 0;
        v = s_lru[a[8:5]];
        if (s_tag[a[8:5]][v][24] && s_tag[a[8:5]][v][23]) return 5 + 2 * lat;
        return 4 + lat;
    endfunction

    // 2-way SRAM with LRU: hit way on a hit, LRU way otherwise.
    always_comb begin
        sram_hit_i = 1'b0;
        hit_way    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (s_tag[sram_addr_o][k][24] && s_tag[sram_addr_o][k][22:0] == sram_tag_o[22:0]) begin
                sram_hit_i = 1'b1;
                hit_way    = k[0];
            end
        end
        sram_tag_i  = s_tag[sram_addr_o][sram_hit_i ? hit_way : s_lru[sram_addr_o]];
        sram_data_i = s_data[sram_addr_o][sram_hit_i ? hit_way : s_lru[sram_addr_o]];
    end

    // SRAM write checker and array update.
    initial begin
        logic do_wr, do_touch, way;
        logic [3:0] set;
        logic [24:0] wtag;
        logic [255:0] wline, expl;
        forever begin
            @(negedge clk);
            do_wr = 1'b0;
            do_touch = 1'b0;
            set = sram_addr_o;
            way = sram_hit_i ? hit_way : s_lru[sram_addr_o];
            if (sram_write_o) begin
                do_wr = 1'b1;
                wtag = sram_tag_o;
                wline = sram_data_o;
                sram_wr_cnt++;
                if (refill_pending) begin
                    refill_pending = 1'b0;
                    check("refill_line", sram_data_o, last_refill);
                    check("refill_tag", 256'(sram_tag_o), 256'({2'b10, cpu_addr_i[31:9]}));
                end else if (cpu_MemWrite_i && sram_hit_i) begin
                    expl = sram_data_i;
                    expl[{cpu_addr_i[4:2], 5'd0} +: 32] = cpu_data_i;
                    check("store_line", sram_data_o, expl);
                    check("store_tag", 256'(sram_tag_o), 256'({2'b11, cpu_addr_i[31:9]}));
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sram_write actual=1 required=0 state=%0d", dbg_state_o);
                end
            end
            if (sram_enable_o && (sram_hit_i || sram_write_o)) do_touch = 1'b1;
            @(posedge clk);
            #1;
            if (do_wr) begin
                s_tag[set][way]  = wtag;
                s_data[set][way] = wline;
            end
            if (do_touch) s_lru[set] = ~way;
        end
    end

    // Main memory responder: acks mem_lat cycles after each request pulse.
    initial begin
        int l;
        logic is_wr;
        logic [255:0] rdata;
        forever begin
            @(negedge clk);
            if (spur_req) begin
                spur_req = 1'b0;
                @(posedge clk); #1 mem_ack_i = 1'b1;
                @(posedge clk); #1 mem_ack_i = 1'b0;
            end else if (mem_enable_o) begin
                is_wr = mem_write_o;
                l = find_line(mem_addr_o);
                rdata = 256'(0);
                check("mem_addr_known", 256'(l >= 0), 256'(1));
                if (is_wr) begin
                    wb_cnt++;
                    last_wb_addr = mem_addr_o;
                    last_wb_data = mem_data_o;
                    check("wb_set", 256'(mem_addr_o[8:0]), 256'({cpu_addr_i[8:5], 5'd0}));
                    if (l >= 0) begin
                        check("wb_line", mem_data_o, arch[l]);
                        phys[l] = mem_data_o;
                    end
                end else begin
                    rd_cnt++;
                    last_rd_addr = mem_addr_o;
                    check("rd_addr", 256'(mem_addr_o), 256'({cpu_addr_i[31:5], 5'd0}));
                    if (l >= 0) rdata = phys[l];
                end
                repeat (mem_lat) @(posedge clk);
                #1;
                mem_ack_i = 1'b1;
                mem_data_i = is_wr ? {8{$urandom}} : rdata;
                if (!is_wr) begin
                    last_refill = rdata;
                    refill_pending = 1'b1;
                end
                @(posedge clk); #1 mem_ack_i = 1'b0;
                ack_cnt++;
            end
        end
    end

    // Completion monitor: pops one expectation per finished request.
    initial begin
        logic [40:0] e;
        forever begin
            @(negedge clk);
            if (!rst_i || !(cpu_MemRead_i || cpu_MemWrite_i)) stall_cnt = 0;
            else if (cpu_stall_o) stall_cnt++;
            else begin
                last_stall = stall_cnt;
                stall_cnt = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    check("stall_cycles", 256'(last_stall), 256'(e[40:33]));
                    if (e[32]) begin
                        last_load = cpu_data_o;
                        check("load_data", 256'(cpu_data_o), 256'(e[31:0]));
                    end
                end
            end
        end
    end

    task automatic wait_done();
        int cyc = 0;
        forever begin
            @(negedge clk); #1;
            if (!cpu_stall_o) break;
            cyc++;
            if (cyc > 60) begin
                failures++;
                $display("FAIL request_timeout actual=stalled required=complete addr=%h", cpu_addr_i);
                report();
            end
        end
        @(posedge clk); #2;
    endtask

    // Called at posedge+2: issue a request, record expectations, wait for completion.
    task automatic do_req(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] d, input int lat);
        int l, st;
        l = find_line(a);
        st = pred_stall(a, lat);
        exp_q.push_back({st[7:0], ~wr, arch[l][{a[4:2], 5'd0} +: 32]});
        if (wr) arch[l][{a[4:2], 5'd0} +: 32] = d;
        mem_lat = lat;
        cpu_addr_i = a;
        cpu_data_i = d;
        cpu_MemRead_i = rd;
        cpu_MemWrite_i = wr;
        wait_done();
    endtask

    task automatic idle(input int n);
        cpu_MemRead_i = 1'b0;
        cpu_MemWrite_i = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int rd0, wb0, wr0, ack0, w, cyc, l;
        logic [31:0] a, d;
        logic [255:0] el;
        rst_i = 1'b0;
        cpu_addr_i = '0; cpu_data_i = '0; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
        mem_ack_i = 1'b0; mem_data_i = '0; spur_req = 1'b0; refill_pending = 1'b0;
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 8; k++) phys[i][32*k +: 32] = 32'hC0DE0000 + 32'(i * 16 + k);
        end
        phys[2][31:0] = 32'hDEADBEEF;
        for (int i = 0; i < 64; i++) arch[i] = phys[i];
        for (int i = 0; i < 16; i++) begin
            s_lru[i] = 1'b0;
            for (int k = 0; k < 2; k++) begin s_tag[i][k] = '0; s_data[i][k] = '0; end
        end

        // Reset values and combinational stall during reset.
        @(negedge clk); #1;
        check("rst_state", 256'(dbg_state_o), 256'(0));
        check("rst_mem_enable", 256'(mem_enable_o), 256'(0));
        check("rst_mem_write", 256'(mem_write_o), 256'(0));
        check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        check("rst_mem_data", mem_data_o, 256'(0));
        check("rst_stall_idle", 256'(cpu_stall_o), 256'(0));
        cpu_addr_i = 32'h40; cpu_MemRead_i = 1'b1; #1;
        check("rst_stall_req", 256'(cpu_stall_o), 256'(1));
        cpu_MemRead_i = 1'b0;
        @(posedge clk); #2 rst_i = 1'b1;
        @(posedge clk); #2;

        // Cold clean load miss.
        rd0 = rd_cnt; wb0 = wb_cnt;
        do_req(32'h40, 1'b1, 1'b0, 32'h0, 2);
        check("t1_stall", 256'(last_stall), 256'(6));
        check("t1_data", 256'(last_load), 256'(32'hDEADBEEF));
        check("t1_rd_pulses", 256'(rd_cnt - rd0), 256'(1));
        check("t1_wb_pulses", 256'(wb_cnt - wb0), 256'(0));
        check("t1_rd_addr", 256'(last_rd_addr), 256'(32'h40));
        w = find_way(32'h40);
        check("t1_resident", 256'(w >= 0), 256'(1));
        if (w >= 0) check("t1_sram_tag", 256'(s_tag[2][w]), 256'({2'b10, 23'h0}));

        // Store hit merges into the line and sets dirty.
        rd0 = rd_cnt; wb0 = wb_cnt;
        do_req(32'h44, 1'b0, 1'b1, 32'h12345678, 2);
        check("t2_stall", 256'(last_stall), 256'(0));
        check("t2_mem_ops", 256'((rd_cnt - rd0) + (wb_cnt - wb0)), 256'(0));
        w = find_way(32'h44);
        check("t2_resident", 256'(w >= 0), 256'(1));
        if (w >= 0) begin
            check("t2_sram_tag", 256'(s_tag[2][w]), 256'({2'b11, 23'h0}));
            check("t2_word1", 256'(s_data[2][w][63:32]), 256'(32'h12345678));
        end

        // Both ways of set 2 dirty, then a third tag evicts the LRU dirty line.
        do_req({tag_tab[1], 4'd2, 3'd0, 2'd0}, 1'b0, 1'b1, 32'hA5A50001, 1);
        rd0 = rd_cnt; wb0 = wb_cnt;
        do_req({tag_tab[2], 4'd2, 3'd5, 2'd0}, 1'b1, 1'b0, 32'h0, 3);
        check("t3_stall", 256'(last_stall), 256'(11));
        check("t3_wb_pulses", 256'(wb_cnt - wb0), 256'(1));
        check("t3_rd_pulses", 256'(rd_cnt - rd0), 256'(1));
        check("t3_wb_addr", 256'(last_wb_addr), 256'(32'h40));
        check("t3_wb_word0", 256'(last_wb_data[31:0]), 256'(32'hDEADBEEF));
        check("t3_wb_word1", 256'(last_wb_data[63:32]), 256'(32'h12345678));

        // Store miss to a clean set: refill then merge.
        a = {tag_tab[3], 4'd5, 3'd3, 2'd0};
        d = 32'h0BADF00D;
        l = find_line(a);
        el = phys[l];
        el[96 +: 32] = d;
        do_req(a, 1'b0, 1'b1, d, 2);
        check("t4_stall", 256'(last_stall), 256'(6));
        w = find_way(a);
        check("t4_resident", 256'(w >= 0), 256'(1));
        if (w >= 0) begin
            check("t4_line", s_data[5][w], el);
            check("t4_dirty_tag", 256'(s_tag[5][w]), 256'({2'b11, tag_tab[3]}));
        end

        // Reset while waiting on a refill; ack lands after release.
        rd0 = rd_cnt;
        mem_lat = 6;
        cpu_addr_i = 32'hE0; cpu_MemRead_i = 1'b1; cpu_MemWrite_i = 1'b0;
        cyc = 0;
        while (rd_cnt == rd0 && cyc < 20) begin @(negedge clk); #1; cyc++; end
        check("t5_read_issued", 256'(rd_cnt - rd0), 256'(1));
        wr0 = sram_wr_cnt; ack0 = ack_cnt;
        @(posedge clk); #2 rst_i = 1'b0; cpu_MemRead_i = 1'b0;
        @(negedge clk); #1;
        check("t5_rst_state", 256'(dbg_state_o), 256'(0));
        check("t5_rst_mem_addr", 256'(mem_addr_o), 256'(0));
        @(posedge clk); #2 rst_i = 1'b1;
        cyc = 0;
        while (ack_cnt == ack0 && cyc < 20) begin @(negedge clk); #1; cyc++; end
        check("t5_ack_seen", 256'(ack_cnt - ack0), 256'(1));
        repeat (3) @(negedge clk);
        #1;
        check("t5_state_idle", 256'(dbg_state_o), 256'(0));
        check("t5_mem_enable", 256'(mem_enable_o), 256'(0));
        check("t5_no_sram_write", 256'(sram_wr_cnt - wr0), 256'(0));
        refill_pending = 1'b0;
        @(posedge clk); #2;

        // Spurious ack with no request outstanding.
        rd0 = rd_cnt; wb0 = wb_cnt; wr0 = sram_wr_cnt;
        spur_req = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("t6_state_idle", 256'(dbg_state_o), 256'(0));
        check("t6_no_mem_ops", 256'((rd_cnt - rd0) + (wb_cnt - wb0)), 256'(0));
        check("t6_no_sram_write", 256'(sram_wr_cnt - wr0), 256'(0));
        check("t6_mem_enable", 256'(mem_enable_o), 256'(0));

        // Random traffic concentrated on a few sets to force evictions.
        for (int i = 0; i < 200; i++) begin
            int op;
            logic [3:0] ix;
            ix = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            a = {tag_tab[$urandom_range(0, 3)], ix, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            op = $urandom_range(0, 2);
            do_req(a, op != 1, op != 0, $urandom, $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);
        check("queue_empty", 256'(exp_q.size()), 256'(0));
        report();
    end

endmodule
